// File: rtl/dm_block_mover_pkg.sv
// Shared definitions for the data-memory block mover.
//   DM_ADDR_W / DM_DATA_W : default data-memory address and data widths
//   MODE_COPY / MODE_FILL : values of the mode request input
//   dm_state_t            : transfer sequencer states
package dm_block_mover_pkg;

    localparam int unsigned DM_ADDR_W = 5;
    localparam int unsigned DM_DATA_W = 32;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_FIN
    } dm_state_t;

endpackage

// File: rtl/dm_block_mover_if.sv
// Request/completion handshake plus data-memory port of the block mover.
//   start, mode, src, dst, len, fill_val : request from the control unit
//   busy, done, err                      : status back to the control unit
//   dm_addr, dm_wd, dm_we                : address/write port towards data memory
//   dm_rd                                : combinational read data from data memory
// Modports:
//   master : environment side (control unit and data memory)
//   slave  : the block mover itself
interface dm_block_mover_if
    import dm_block_mover_pkg::*;
#(
    parameter int unsigned ADDR_W = DM_ADDR_W,
    parameter int unsigned DATA_W = DM_DATA_W
) ();

    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W:0]   len;
    logic [DATA_W-1:0] fill_val;

    logic              busy;
    logic              done;
    logic              err;

    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wd;
    logic              dm_we;
    logic [DATA_W-1:0] dm_rd;

    modport master (
        output start, mode, src, dst, len, fill_val, dm_rd,
        input  busy, done, err, dm_addr, dm_wd, dm_we
    );

    modport slave (
        input  start, mode, src, dst, len, fill_val, dm_rd,
        output busy, done, err, dm_addr, dm_wd, dm_we
    );

endinterface

// File: rtl/dm_block_mover.sv
// Block copy / block fill engine for the single-port data memory.
// Ports:
//   clk  : system clock, all state updates on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : dm_block_mover_if.slave (request, status and data-memory port)
// A copy moves one word per two cycles (read, then write); a fill writes one
// word per cycle. Words are processed in ascending index order and addresses
// wrap modulo the memory depth. All outputs decode registered state only.
module dm_block_mover
    import dm_block_mover_pkg::*;
#(
    parameter int unsigned ADDR_W = DM_ADDR_W,
    parameter int unsigned DATA_W = DM_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    dm_block_mover_if.slave     bus
);

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    dm_state_t         state_r;
    dm_state_t         state_nxt;

    logic              mode_r;
    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [ADDR_W:0]   len_r;
    logic [DATA_W-1:0] fill_r;
    logic [DATA_W-1:0] data_r;
    logic              err_r;
    logic [ADDR_W:0]   idx_r;
    logic [ADDR_W:0]   idx_inc;
    logic              accept;
    logic              len_bad;

    assign idx_inc = idx_r + ONE;
    assign accept  = (state_r == ST_IDLE) && bus.start;
    assign len_bad = (bus.len > MAX_LEN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_r;
        unique case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    // Empty and oversized requests complete without touching memory.
                    if ((bus.len == '0) || len_bad) begin
                        state_nxt = ST_FIN;
                    end else if (bus.mode == MODE_FILL) begin
                        state_nxt = ST_WR;
                    end else begin
                        state_nxt = ST_RD;
                    end
                end
            end
            ST_RD: begin
                state_nxt = ST_WR;
            end
            ST_WR: begin
                if (idx_inc == len_r) begin
                    state_nxt = ST_FIN;
                end else if (mode_r == MODE_COPY) begin
                    state_nxt = ST_RD;
                end else begin
                    state_nxt = ST_WR;
                end
            end
            ST_FIN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r <= MODE_COPY;
            src_r  <= '0;
            dst_r  <= '0;
            len_r  <= '0;
            fill_r <= '0;
            data_r <= '0;
            err_r  <= 1'b0;
            idx_r  <= '0;
        end else begin
            if (accept) begin
                mode_r <= bus.mode;
                src_r  <= bus.src;
                dst_r  <= bus.dst;
                len_r  <= bus.len;
                fill_r <= bus.fill_val;
                err_r  <= len_bad;
                idx_r  <= '0;
            end
            if (state_r == ST_RD) begin
                data_r <= bus.dm_rd;
            end
            if (state_r == ST_WR) begin
                idx_r <= idx_inc;
            end
        end
    end

    // Address sums are ADDR_W wide, so src+i / dst+i wrap at the memory depth.
    always_comb begin
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.err     = 1'b0;
        bus.dm_we   = 1'b0;
        bus.dm_addr = '0;
        bus.dm_wd   = '0;
        unique case (state_r)
            ST_RD: begin
                bus.busy    = 1'b1;
                bus.dm_addr = src_r + idx_r[ADDR_W-1:0];
            end
            ST_WR: begin
                bus.busy    = 1'b1;
                bus.dm_we   = 1'b1;
                bus.dm_addr = dst_r + idx_r[ADDR_W-1:0];
                bus.dm_wd   = (mode_r == MODE_FILL) ? fill_r : data_r;
            end
            ST_FIN: begin
                bus.done = 1'b1;
                bus.err  = err_r;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dm_block_mover.sv
// Self-checking bench for dm_block_mover: a behavioural memory plus a
// reference model that applies each request word by word to an array and
// derives the expected completion timing from the request length and mode.
module tb_dm_block_mover;
    import dm_block_mover_pkg::*;

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned BUDGET = 80;

    logic clk = 1'b0;
    logic rst;

    dm_block_mover_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dm_block_mover #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem      [DEPTH];
    logic [DW-1:0] load_img [DEPTH];
    logic [DW-1:0] ref_mem  [DEPTH];
    logic          load_en = 1'b0;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    assign bus.dm_rd = mem[bus.dm_addr];

    always @(posedge clk) begin
        if (load_en) begin
            for (int unsigned k = 0; k < DEPTH; k++) mem[k] <= load_img[k];
        end else if (bus.dm_we) begin
            mem[bus.dm_addr] <= bus.dm_wd;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_mem();
        for (int unsigned k = 0; k < DEPTH; k++) ref_mem[k] = load_img[k];
        load_en = 1'b1;
        @(posedge clk);
        #1 load_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic random_image();
        for (int unsigned k = 0; k < DEPTH; k++) load_img[k] = $urandom;
    endtask

    task automatic scramble_operands();
        bus.mode     = 1'($urandom_range(0, 1));
        bus.src      = AW'($urandom);
        bus.dst      = AW'($urandom);
        bus.len      = (AW+1)'($urandom_range(1, 32));
        bus.fill_val = $urandom;
    endtask

    task automatic check_mem(input string name);
        int unsigned bad_words;
        bad_words = 0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (mem[k] !== ref_mem[k]) begin
                bad_words++;
                $display("FAIL %s word %0d: got %h expected %h", name, k, mem[k], ref_mem[k]);
            end
        end
        check_eq({name, " memory words wrong"}, 64'(bad_words), 64'd0);
    endtask

    // Called at a falling edge with the mover idle. extra_at > 0 raises a
    // second start during that cycle number of the transfer (must be ignored).
    task automatic run_req(input string name, input logic m, input logic [AW-1:0] s,
                           input logic [AW-1:0] d, input logic [AW:0] n,
                           input logic [DW-1:0] f, input int unsigned extra_at);
        int unsigned exp_done, exp_busy, exp_we;
        int unsigned busy_cnt, we_cnt, odd_we, done_cyc;
        logic        exp_err, err_seen, busy_at_done;

        exp_err = (n > DEPTH);
        if (exp_err || (n == 0)) begin
            exp_done = 1; exp_busy = 0; exp_we = 0;
        end else begin
            for (int unsigned k = 0; k < n; k++)
                ref_mem[(d + k) % DEPTH] = (m == MODE_COPY) ? ref_mem[(s + k) % DEPTH] : f;
            exp_we   = n;
            exp_busy = (m == MODE_COPY) ? 2 * n : n;
            exp_done = exp_busy + 1;
        end

        bus.start = 1'b1; bus.mode = m; bus.src = s; bus.dst = d; bus.len = n; bus.fill_val = f;
        @(negedge clk);
        busy_cnt = 0; we_cnt = 0; odd_we = 0; done_cyc = 0;
        err_seen = 1'b0; busy_at_done = 1'b0;
        for (int unsigned c = 1; c <= BUDGET; c++) begin
            if (bus.busy) busy_cnt++;
            if (bus.dm_we) begin
                we_cnt++;
                if ((m == MODE_COPY) && (c % 2 == 1)) odd_we++;
            end
            if (bus.done) begin
                done_cyc = c; err_seen = bus.err; busy_at_done = bus.busy;
            end
            scramble_operands();
            bus.start = (c == extra_at);
            if (bus.done) break;
            @(negedge clk);
        end

        check_eq({name, " done cycle"}, 64'(done_cyc), 64'(exp_done));
        check_eq({name, " err"}, 64'(err_seen), 64'(exp_err));
        check_eq({name, " busy cycles"}, 64'(busy_cnt), 64'(exp_busy));
        check_eq({name, " write cycles"}, 64'(we_cnt), 64'(exp_we));
        check_eq({name, " busy at done"}, 64'(busy_at_done), 64'd0);
        if (m == MODE_COPY) check_eq({name, " write in odd cycle"}, 64'(odd_we), 64'd0);

        @(negedge clk);
        check_eq({name, " busy after done"}, 64'(bus.busy), 64'd0);
        check_eq({name, " done after done"}, 64'(bus.done), 64'd0);
        bus.start = 1'b0;
        check_mem(name);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned late_done;
        logic [AW:0] n;
        int unsigned xa;
        logic m;

        rst = 1'b1;
        bus.start = 1'b0; bus.mode = MODE_COPY; bus.src = '0; bus.dst = '0;
        bus.len = '0; bus.fill_val = '0;
        #1;
        check_eq("reset busy", 64'(bus.busy), 64'd0);
        check_eq("reset done", 64'(bus.done), 64'd0);
        check_eq("reset err", 64'(bus.err), 64'd0);
        check_eq("reset we", 64'(bus.dm_we), 64'd0);
        check_eq("reset addr", 64'(bus.dm_addr), 64'd0);
        check_eq("reset wd", 64'(bus.dm_wd), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        random_image();
        load_mem();

        run_req("fill4", MODE_FILL, 5'd0, 5'd4, 6'd3, 32'hA5A5A5A5, 0);
        check_eq("fill4 word6", 64'(mem[6]), 64'hA5A5A5A5);

        for (int unsigned k = 0; k < DEPTH; k++) load_img[k] = ref_mem[k];
        load_img[0] = 32'hDEADBEEF;
        load_img[1] = 32'h12345678;
        load_mem();
        run_req("copy2", MODE_COPY, 5'd0, 5'd10, 6'd2, 32'h0, 0);
        check_eq("copy2 word10", 64'(mem[10]), 64'hDEADBEEF);
        check_eq("copy2 word11", 64'(mem[11]), 64'h12345678);

        run_req("wrap", MODE_FILL, 5'd0, 5'd30, 6'd4, 32'hFFFFFFFF, 0);
        run_req("len0", MODE_COPY, 5'd3, 5'd7, 6'd0, 32'h0, 0);
        run_req("len33", MODE_FILL, 5'd3, 5'd7, 6'd33, 32'h11111111, 0);
        run_req("len32", MODE_FILL, 5'd0, 5'd9, 6'd32, 32'h5A5A0F0F, 0);

        random_image();
        load_mem();
        run_req("startbusy", MODE_COPY, 5'd5, 5'd12, 6'd3, 32'h0, 2);
        run_req("startfin", MODE_FILL, 5'd0, 5'd20, 6'd2, 32'hCAFEF00D, 3);
        run_req("overlap", MODE_COPY, 5'd4, 5'd5, 6'd6, 32'h0, 0);

        // Abort a copy in its second write cycle: only the first word lands.
        random_image();
        load_mem();
        bus.start = 1'b1; bus.mode = MODE_COPY; bus.src = 5'd3; bus.dst = 5'd20; bus.len = 6'd4;
        ref_mem[20] = ref_mem[3];
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_eq("abort we before reset", 64'(bus.dm_we), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("abort we", 64'(bus.dm_we), 64'd0);
        check_eq("abort busy", 64'(bus.busy), 64'd0);
        check_eq("abort done", 64'(bus.done), 64'd0);
        check_eq("abort addr", 64'(bus.dm_addr), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        late_done = 0;
        for (int unsigned c = 0; c < 4; c++) begin
            if (bus.done || bus.busy) late_done++;
            @(negedge clk);
        end
        check_eq("abort no activity", 64'(late_done), 64'd0);
        check_mem("abort");
        run_req("after abort", MODE_COPY, 5'd28, 5'd1, 6'd5, 32'h0, 0);

        for (int unsigned it = 0; it < 25; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                random_image();
                load_mem();
            end
            m = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) n = (AW+1)'($urandom_range(0, 40));
            else n = (AW+1)'($urandom_range(1, 10));
            xa = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : 0;
            run_req("random", m, AW'($urandom), AW'($urandom), n, $urandom, xa);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dm_block_mover.md
# dm_block_mover

Bus-initiator block that drives the single-port data memory (32 × 32-bit, combinational read, write on rising clock edge when write-enable is high). It performs block copy or block fill inside the data memory on request, freeing the datapath from word-by-word load/store loops. It sits between the control unit (start/done handshake) and the data memory address/write-data/write-enable/read-data port, through a mux owned by the top level.

## Interface
Parameters:
- ADDR_W, 5, data-memory address width (depth 2^ADDR_W words)
- DATA_W, 32, data word width

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- mode  in  1  0 = copy, 1 = fill
- src  in  ADDR_W  copy source base address (ignored in fill)
- dst  in  ADDR_W  destination base address
- len  in  ADDR_W+1  word count, legal 0..2^ADDR_W
- fill_val  in  DATA_W  fill pattern (ignored in copy)
- busy  out  1  high while a transfer is in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with done, when request rejected
- dm_addr  out  ADDR_W  address to data memory
- dm_wd  out  DATA_W  write data to data memory
- dm_we  out  1  write enable to data memory
- dm_rd  in  DATA_W  read data from data memory (combinational w.r.t. dm_addr)

## Operation
- States: IDLE, RD, WR, FIN.
- IDLE: dm_we=0, busy=0. On start=1: capture src, dst, len, mode, fill_val; clear word index i.
  - len=0 → FIN, no memory access, err=0.
  - len>2^ADDR_W → FIN with err flag set, no memory access.
  - copy → RD; fill → WR.
- RD (copy only): dm_addr=src+i, dm_we=0; at clock edge latch dm_rd into data register; → WR.
- WR: dm_addr=dst+i, dm_wd = data register (copy) or fill_val (fill), dm_we=1. At edge i←i+1; if i+1==len → FIN, else → RD (copy) / WR (fill).
- FIN: done=1 (and err=1 if flagged) for exactly one cycle; → IDLE.
- Address arithmetic: src+i and dst+i are computed modulo 2^ADDR_W (wrap 31→0).
- Overlapping ranges: strictly ascending word order, one read before each write; copy with dst>src overlap propagates already-written words (defined, not corrected).
- start while busy or in FIN: ignored, not queued.
- Inputs other than start are don't-care outside the start cycle.

## Timing
- Reset (async, immediate): state=IDLE, busy=0, done=0, err=0, dm_we=0, dm_addr=0, dm_wd=0, i=0, data register=0. Reset mid-transfer aborts; no done pulse; writes already performed remain.
- start sampled at edge 0 → first RD/WR cycle is cycle 1.
- Copy of N words: busy high cycles 1..2N; writes in even cycles 2,4,…,2N; done in cycle 2N+1.
- Fill of N words: busy high cycles 1..N, one write per cycle; done in cycle N+1.
- len=0 or illegal: busy stays 0; done (and err if illegal) in cycle 1.
- New start accepted earliest in the cycle after done (back-to-back requests: done cycle + 1).
- busy is low in FIN.

## Structure
- Shared package: state encoding (IDLE/RD/WR/FIN), mode constants MODE_COPY/MODE_FILL, default ADDR_W/DATA_W.
- Single module; no sub-module needed. All outputs decoded from registered state, index and captured operands (no input-to-output combinational path except dm_rd → data register).

## Test plan
- Fill: mode=1, dst=4, len=3, fill_val=A5A5A5A5 → words 4,5,6 = A5A5A5A5, word 7 unchanged, done at cycle 4, busy cycles 1–3.
- Copy: preload 0=DEADBEEF,1=12345678; mode=0, src=0, dst=10, len=2 → words 10,11 = DEADBEEF,12345678; dm_we high only cycles 2 and 4; done cycle 5.
- Wrap: fill dst=30, len=4, fill_val=FFFFFFFF → words 30,31,0,1 written; word 2 untouched.
- Boundaries: len=0 → done cycle 1, err=0, no dm_we; len=33 → done+err cycle 1, no dm_we; len=32 fill → all 32 words written, done cycle 33.
- start during busy: second start at cycle 2 of a copy ignored; only original transfer occurs, single done pulse.
- Async reset mid-copy (len=4, rst at cycle 3): dm_we drops immediately, busy=0, no done; only word dst+0 written; subsequent start works normally.
